// File: rtl/l2_rr_port_arbiter.sv
// Round-robin arbiter between NUM_PORTS L2 requester ports and one L2 memory port.
// Each request is forwarded with id {port, sub_id}. A write holds the arbiter on its
// port until the whole burst has been moved. Read returns go back to the owning port by id.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB      | offer the granted (or held) request; accept pops
// WR_BURST | steer write words from wr_port until wr_count reaches zero
module l2_rr_port_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int SUB_ID_W  = 2,
    parameter int DATA_W    = 32,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int ID_W      = PORT_W + SUB_ID_W
) (
    input  logic                          clk,
    input  logic                          rst,

    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS*30-1:0]       req_addr,
    input  logic [NUM_PORTS*4-1:0]        req_be,
    input  logic [NUM_PORTS-1:0]          req_rnw,
    input  logic [NUM_PORTS-1:0]          req_is_amo,
    input  logic [NUM_PORTS*5-1:0]        req_amo_type_or_burst_size,
    input  logic [NUM_PORTS*SUB_ID_W-1:0] req_sub_id,
    output logic [NUM_PORTS-1:0]          req_pop,

    input  logic [NUM_PORTS*DATA_W-1:0]   wr_data,
    input  logic [NUM_PORTS-1:0]          wr_data_valid,
    output logic [NUM_PORTS-1:0]          wr_data_read,

    output logic [29:0]                   mem_addr,
    output logic [3:0]                    mem_be,
    output logic                          mem_rnw,
    output logic                          mem_is_amo,
    output logic [4:0]                    mem_amo_type_or_burst_size,
    output logic [ID_W-1:0]               mem_id,
    output logic                          mem_request_valid,
    input  logic                          mem_request_pop,

    output logic [DATA_W-1:0]             mem_wr_data,
    output logic                          mem_wr_data_valid,
    input  logic                          mem_wr_data_read,

    input  logic [DATA_W-1:0]             mem_rd_data,
    input  logic [ID_W-1:0]               mem_rd_id,
    input  logic                          mem_rd_data_valid,
    output logic [DATA_W-1:0]             rd_data,
    output logic [SUB_ID_W-1:0]           rd_sub_id,
    output logic [NUM_PORTS-1:0]          rd_data_valid
);

    typedef enum logic {ARB = 1'b0, WR_BURST = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [PORT_W-1:0]   rr_ptr;
    logic                grant_held;
    logic [PORT_W-1:0]   held_port;
    logic [PORT_W-1:0]   wr_port;
    logic [5:0]          wr_count;

    logic [PORT_W-1:0]   arb_port;
    logic [PORT_W:0]     cand;
    logic [PORT_W-1:0]   gnt;
    logic                req_accept;
    logic                word_read;

    // Round-robin search: lowest offset from rr_ptr with a valid request wins.
    always_comb begin
        arb_port = rr_ptr;
        cand     = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr} + (PORT_W+1)'(i);
            if (cand >= (PORT_W+1)'(NUM_PORTS))
                cand = cand - (PORT_W+1)'(NUM_PORTS);
            if (req_valid[cand[PORT_W-1:0]])
                arb_port = cand[PORT_W-1:0];
        end
    end

    // Field mux, FSM next state and handshake outputs; rst forces idle outputs.
    always_comb begin
        gnt                        = grant_held ? held_port : arb_port;
        mem_addr                   = req_addr[int'(gnt)*30 +: 30];
        mem_be                     = req_be[int'(gnt)*4 +: 4];
        mem_rnw                    = req_rnw[gnt];
        mem_is_amo                 = req_is_amo[gnt];
        mem_amo_type_or_burst_size = req_amo_type_or_burst_size[int'(gnt)*5 +: 5];
        mem_id                     = {gnt, req_sub_id[int'(gnt)*SUB_ID_W +: SUB_ID_W]};
        mem_wr_data                = wr_data[int'(wr_port)*DATA_W +: DATA_W];

        state_nxt         = state;
        mem_request_valid = 1'b0;
        req_accept        = 1'b0;
        req_pop           = '0;
        mem_wr_data_valid = 1'b0;
        word_read         = 1'b0;
        wr_data_read      = '0;

        if (!rst) begin
            case (state)
                ARB: begin
                    mem_request_valid = grant_held | (|req_valid);
                    req_accept        = mem_request_valid & mem_request_pop;
                    if (req_accept) begin
                        req_pop[gnt] = 1'b1;
                        if (!req_rnw[gnt])
                            state_nxt = WR_BURST;
                    end
                end
                WR_BURST: begin
                    mem_wr_data_valid     = wr_data_valid[wr_port];
                    word_read             = mem_wr_data_read & mem_wr_data_valid;
                    wr_data_read[wr_port] = word_read;
                    if (word_read && wr_count == 6'd1)
                        state_nxt = ARB;
                end
                default: state_nxt = ARB;
            endcase
        end
    end

    // State, round-robin pointer, grant hold and write-burst counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            rr_ptr     <= '0;
            grant_held <= 1'b0;
            held_port  <= '0;
            wr_port    <= '0;
            wr_count   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB) begin
                if (req_accept) begin
                    grant_held <= 1'b0;
                    rr_ptr     <= (gnt == PORT_W'(NUM_PORTS - 1)) ? '0 : gnt + 1'b1;
                    if (!mem_rnw) begin
                        wr_port  <= gnt;
                        wr_count <= mem_is_amo ? 6'd1
                                               : {1'b0, mem_amo_type_or_burst_size} + 6'd1;
                    end
                end else if (mem_request_valid) begin
                    grant_held <= 1'b1;
                    held_port  <= gnt;
                end
            end else if (word_read) begin
                wr_count <= wr_count - 6'd1;
            end
        end
    end

    // Read return: data broadcast, owner strobe decoded from the id port field.
    always_comb begin
        rd_data       = mem_rd_data;
        rd_sub_id     = mem_rd_id[SUB_ID_W-1:0];
        rd_data_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            rd_data_valid[p] = !rst & mem_rd_data_valid
                               & (mem_rd_id[ID_W-1 -: PORT_W] == PORT_W'(p));
    end

endmodule

// File: tb/tb_l2_rr_port_arbiter.sv
// Directed bench for l2_rr_port_arbiter with an expected-grant / expected-word scoreboard.
module tb_l2_rr_port_arbiter;

    localparam int NP  = 4;
    localparam int SW  = 2;
    localparam int DW  = 32;
    localparam int PW  = 2;
    localparam int IDW = PW + SW;

    logic               clk = 1'b0;
    logic               rst;
    logic [NP-1:0]      req_valid;
    logic [NP*30-1:0]   req_addr;
    logic [NP*4-1:0]    req_be;
    logic [NP-1:0]      req_rnw;
    logic [NP-1:0]      req_is_amo;
    logic [NP*5-1:0]    req_amo_type_or_burst_size;
    logic [NP*SW-1:0]   req_sub_id;
    logic [NP-1:0]      req_pop;
    logic [NP*DW-1:0]   wr_data;
    logic [NP-1:0]      wr_data_valid;
    logic [NP-1:0]      wr_data_read;
    logic [29:0]        mem_addr;
    logic [3:0]         mem_be;
    logic               mem_rnw;
    logic               mem_is_amo;
    logic [4:0]         mem_amo_type_or_burst_size;
    logic [IDW-1:0]     mem_id;
    logic               mem_request_valid;
    logic               mem_request_pop;
    logic [DW-1:0]      mem_wr_data;
    logic               mem_wr_data_valid;
    logic               mem_wr_data_read;
    logic [DW-1:0]      mem_rd_data;
    logic [IDW-1:0]     mem_rd_id;
    logic               mem_rd_data_valid;
    logic [DW-1:0]      rd_data;
    logic [SW-1:0]      rd_sub_id;
    logic [NP-1:0]      rd_data_valid;

    l2_rr_port_arbiter #(.NUM_PORTS(NP), .SUB_ID_W(SW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_be(req_be), .req_rnw(req_rnw),
        .req_is_amo(req_is_amo), .req_amo_type_or_burst_size(req_amo_type_or_burst_size),
        .req_sub_id(req_sub_id), .req_pop(req_pop),
        .wr_data(wr_data), .wr_data_valid(wr_data_valid), .wr_data_read(wr_data_read),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_rnw(mem_rnw), .mem_is_amo(mem_is_amo),
        .mem_amo_type_or_burst_size(mem_amo_type_or_burst_size), .mem_id(mem_id),
        .mem_request_valid(mem_request_valid), .mem_request_pop(mem_request_pop),
        .mem_wr_data(mem_wr_data), .mem_wr_data_valid(mem_wr_data_valid),
        .mem_wr_data_read(mem_wr_data_read),
        .mem_rd_data(mem_rd_data), .mem_rd_id(mem_rd_id), .mem_rd_data_valid(mem_rd_data_valid),
        .rd_data(rd_data), .rd_sub_id(rd_sub_id), .rd_data_valid(rd_data_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int grant_q[$];
    logic [DW-1:0] word_q[$];
    int pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [SW-1:0] sub_of(input int p);
        return SW'((p + 1) % 4);
    endfunction

    function automatic logic [IDW-1:0] exp_id(input int p);
        return IDW'(p * 4) | IDW'(sub_of(p));
    endfunction

    function automatic logic [29:0] addr_of(input int p);
        return 30'h1000 + 30'(p * 16);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_rnw = '1; req_is_amo = '0;
        req_amo_type_or_burst_size = '0;
        for (int p = 0; p < NP; p++) begin
            req_addr[p*30 +: 30] = addr_of(p);
            req_be[p*4 +: 4]     = 4'(p + 1);
            req_sub_id[p*SW +: SW] = sub_of(p);
        end
        wr_data = '0; wr_data_valid = '0; mem_request_pop = 1'b0; mem_wr_data_read = 1'b0;
        mem_rd_data = '0; mem_rd_id = '0; mem_rd_data_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Pop the next expected grant and compare the offered request against it.
    task automatic check_grant(input string tag, input logic pop_exp);
        int e;
        if (grant_q.size() == 0) begin
            chk({tag, "_q_empty"}, 64'd1, 64'd0);
            return;
        end
        e = grant_q.pop_front();
        chk({tag, "_valid"}, 64'(mem_request_valid), 64'd1);
        chk({tag, "_id"},    64'(mem_id),   64'(exp_id(e)));
        chk({tag, "_addr"},  64'(mem_addr), 64'(addr_of(e)));
        chk({tag, "_pop"},   64'(req_pop),  pop_exp ? 64'(1 << e) : 64'd0);
    endtask

    // Compare any consumed write word with the scoreboard.
    task automatic check_word(input string tag);
        if (wr_data_read != '0) begin
            pulses++;
            if (word_q.size() == 0) chk({tag, "_extra_read"}, 64'(wr_data_read), 64'd0);
            else chk({tag, "_data"}, 64'(mem_wr_data), 64'(word_q.pop_front()));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        step(); step();
        rst = 1'b0;
        #1;
        chk("reset_req_valid", 64'(mem_request_valid), 0);
        chk("reset_req_pop",   64'(req_pop), 0);
        chk("reset_wr_read",   64'(wr_data_read), 0);
        chk("reset_wr_valid",  64'(mem_wr_data_valid), 0);
        chk("reset_rd_valid",  64'(rd_data_valid), 0);

        // Ports 0 and 2 reading, pop every cycle; then all valid must grant port 3.
        do_reset();
        req_valid = 4'b0101; mem_request_pop = 1'b1;
        grant_q.push_back(0); grant_q.push_back(2); grant_q.push_back(3);
        #1; check_grant("rd02_g0", 1'b1);
        step(); req_valid = 4'b0100;
        #1; check_grant("rd02_g2", 1'b1);
        step(); req_valid = 4'b1111;
        #1; check_grant("rd02_ptr3", 1'b1);
        step();

        // Fairness with all ports continuously valid.
        do_reset();
        req_valid = 4'b1111; mem_request_pop = 1'b1;
        for (int k = 0; k < 5; k++) grant_q.push_back(k % NP);
        for (int k = 0; k < 5; k++) begin
            #1; check_grant($sformatf("fair%0d", k), 1'b1);
            step();
        end

        // Held grant: port 1 stays offered while port 0 appears.
        do_reset();
        req_valid = 4'b0010; mem_request_pop = 1'b0;
        for (int k = 0; k < 3; k++) grant_q.push_back(1);
        #1; check_grant("hold_c1", 1'b0);
        step(); req_valid = 4'b0011;
        for (int k = 2; k <= 3; k++) begin
            #1; check_grant($sformatf("hold_c%0d", k), 1'b0);
            step();
        end
        mem_request_pop = 1'b1; grant_q.push_back(1);
        #1; check_grant("hold_c4", 1'b1);
        step();

        // Port 3 write burst of 4 words, data valid toggling.
        do_reset();
        req_valid = 4'b1000; req_rnw = 4'b0111; mem_request_pop = 1'b1;
        req_amo_type_or_burst_size[3*5 +: 5] = 5'd3;
        grant_q.push_back(3);
        #1; check_grant("wr3_req", 1'b1);
        step();
        req_valid = 4'b0001; req_rnw = 4'b1111; mem_wr_data_read = 1'b1; pulses = 0;
        for (int k = 0; k < 5; k++) begin
            logic v;
            v = (k != 1);
            wr_data_valid[3] = v;
            wr_data[3*DW +: DW] = 32'hA000_0000 + 32'(k);
            if (v) word_q.push_back(32'hA000_0000 + 32'(k));
            #1;
            chk($sformatf("wr3_noreq%0d", k), 64'(mem_request_valid), 0);
            chk($sformatf("wr3_rd%0d", k), 64'(wr_data_read), v ? 64'h8 : 64'h0);
            check_word("wr3");
            step();
        end
        #1;
        chk("wr3_pulses", 64'(pulses), 4);
        chk("wr3_q_left", 64'(word_q.size()), 0);
        chk("wr3_no_more_read", 64'(wr_data_read), 0);
        grant_q.push_back(0);
        check_grant("wr3_back_arb", 1'b1);
        step();

        // Port 2 AMO write: burst field ignored, one word only.
        do_reset();
        req_valid = 4'b0100; req_rnw = 4'b1011; req_is_amo = 4'b0100; mem_request_pop = 1'b1;
        req_amo_type_or_burst_size[2*5 +: 5] = 5'd5;
        grant_q.push_back(2);
        #1; check_grant("amo2_req", 1'b1);
        step();
        req_valid = '0; mem_wr_data_read = 1'b1; wr_data_valid = 4'b0100;
        wr_data[2*DW +: DW] = 32'h5A5A_0002; word_q.push_back(32'h5A5A_0002); pulses = 0;
        for (int k = 0; k < 3; k++) begin
            #1; check_word("amo2");
            step();
        end
        chk("amo2_pulses", 64'(pulses), 1);

        // Read return decode.
        do_reset();
        mem_rd_data = 32'hDEAD_BEEF; mem_rd_id = 4'b0110; mem_rd_data_valid = 1'b1;
        #1;
        chk("rd_valid_p1", 64'(rd_data_valid), 64'h2);
        chk("rd_sub",      64'(rd_sub_id), 64'h2);
        chk("rd_data",     64'(rd_data), 64'hDEAD_BEEF);
        mem_rd_id = 4'b1101;
        #1; chk("rd_valid_p3", 64'(rd_data_valid), 64'h8);
        mem_rd_data_valid = 1'b0;
        #1; chk("rd_idle", 64'(rd_data_valid), 0);

        // Reset in the middle of a port 1 burst.
        do_reset();
        req_valid = 4'b0010; req_rnw = 4'b1101; mem_request_pop = 1'b1;
        req_amo_type_or_burst_size[1*5 +: 5] = 5'd7;
        grant_q.push_back(1);
        #1; check_grant("rstb_req", 1'b1);
        step();
        req_valid = '0; req_rnw = '1; wr_data_valid = 4'b0010; mem_wr_data_read = 1'b1;
        #1; chk("rstb_read", 64'(wr_data_read), 64'h2);
        step();
        rst = 1'b1; req_valid = 4'b0101; mem_rd_data_valid = 1'b1; mem_rd_id = 4'b0010;
        #1;
        chk("rstb_in_rst_reqv", 64'(mem_request_valid), 0);
        chk("rstb_in_rst_pop",  64'(req_pop), 0);
        chk("rstb_in_rst_rdv",  64'(rd_data_valid), 0);
        step();
        rst = 1'b0; req_valid = '0; mem_rd_data_valid = 1'b0;
        #1;
        chk("rstb_wr_read",  64'(wr_data_read), 0);
        chk("rstb_wr_valid", 64'(mem_wr_data_valid), 0);
        chk("rstb_reqv",     64'(mem_request_valid), 0);
        req_valid = 4'b0101; grant_q.push_back(0);
        #1; check_grant("rstb_ptr0", 1'b1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/l2_rr_port_arbiter.md
Name: l2_rr_port_arbiter

Overview:
- Parametrised N-port round-robin arbiter between L2 requester ports and the single L2 memory port.
- Replaces fixed-port muxing.
- Muxes requests and tags each one with an id of {port index, sub_id}.
- Steers write-data bursts from the granted port with a locked grant.
- Demuxes read data back to the owning port by id.

Parameters:
- NUM_PORTS, 4: number of requester ports (1..16).
- SUB_ID_W, 2: per-port sub-id width.
- DATA_W, 32: data word width.
- PORT_W, max(1,$clog2(NUM_PORTS)): port-index field width.
- ID_W, PORT_W+SUB_ID_W: memory id width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_PORTS  per-port request present
- req_addr  in  NUM_PORTS*30  word addresses, port p at bits [p*30 +: 30]
- req_be  in  NUM_PORTS*4  byte enables
- req_rnw  in  NUM_PORTS  1=read
- req_is_amo  in  NUM_PORTS  atomic request
- req_amo_type_or_burst_size  in  NUM_PORTS*5  burst length minus 1, or AMO type
- req_sub_id  in  NUM_PORTS*SUB_ID_W  requester tag
- req_pop  out  NUM_PORTS  request consumed this cycle
- wr_data  in  NUM_PORTS*DATA_W  per-port write data
- wr_data_valid  in  NUM_PORTS  write-data FIFO non-empty
- wr_data_read  out  NUM_PORTS  write word consumed
- mem_addr, mem_be, mem_rnw, mem_is_amo, mem_amo_type_or_burst_size  out  30/4/1/1/5  granted request fields
- mem_id  out  ID_W  {port, sub_id}
- mem_request_valid  out  1  request offered
- mem_request_pop  in  1  memory accepted request
- mem_wr_data  out  DATA_W  steered write word
- mem_wr_data_valid  out  1  steered word valid
- mem_wr_data_read  in  1  memory consumed word
- mem_rd_data  in  DATA_W  read return
- mem_rd_id  in  ID_W  read return id
- mem_rd_data_valid  in  1  read return valid
- rd_data  out  DATA_W  broadcast to all ports
- rd_sub_id  out  SUB_ID_W  mem_rd_id[SUB_ID_W-1:0]
- rd_data_valid  out  NUM_PORTS  one-hot owner strobe

Behaviour:
- States: ARB and WR_BURST.
  - Reset enters ARB.
  - Reset sets rr_ptr=0, so port 0 has highest priority.
  - Reset sets grant_held=0 and wr_count=0.
- Reset values of outputs:
  - mem_request_valid=0.
  - req_pop=0.
  - wr_data_read=0.
  - mem_wr_data_valid=0.
  - rd_data_valid=0.
- ARB, no held grant:
  - Grant the first valid port searching rr_ptr, rr_ptr+1, … mod NUM_PORTS.
  - mem_request_valid = |req_valid.
  - Grant and outputs are combinational, same cycle.
- Held grant: if mem_request_valid=1 and mem_request_pop=0, register the grant. The next cycle must present the same port and fields (AXI-style stability); no re-arbitration.
- On mem_request_pop (only valid while mem_request_valid=1):
  - req_pop[g]=1 in the same cycle.
  - rr_ptr <= g+1 mod NUM_PORTS.
  - Grant hold clears.
- Write requests (rnw=0): on pop, latch g and wr_count = is_amo ? 1 : burst+1 (range 1..32).
  - Go to WR_BURST.
  - The pop of a write stays in the same cycle; the next request is not offered until the burst completes.
- WR_BURST:
  - mem_request_valid=0.
  - mem_wr_data = wr_data[g].
  - mem_wr_data_valid = wr_data_valid[g].
  - wr_data_read[g] = mem_wr_data_read.
  - Decrement on each read.
  - When wr_count==1 and a read occurs, return to ARB next cycle.
- Reads and AMO reads: stay in ARB; no data phase.
- mem_wr_data_read while mem_wr_data_valid=0: ignored. No counter change and no wr_data_read.
- Read return is combinational:
  - rd_data_valid[p] = mem_rd_data_valid & (mem_rd_id[ID_W-1 -: PORT_W]==p).
  - A port field >= NUM_PORTS strobes no port.
- NUM_PORTS=1: the port field is constant 0 and arbitration is trivial.
- rst mid-burst or mid-hold: abandon state and return to reset values next cycle. No partial pops are replayed.

Test Plan:
- Ports 0,2 request reads, pop every cycle → grants 0 then 2; mem_id = {0,sub}, {2,sub}; rr_ptr ends at 3.
- All 4 ports valid continuously with pop every cycle → grant order 0,1,2,3,0 (fairness); each req_pop once per 4 cycles.
- Port 1 request, pop held low 3 cycles while port 0 also asserts → fields and mem_id stay port 1's throughout; pop on cycle 4 → req_pop[1] only.
- Port 3 write, burst=3 (4 words), wr_data_valid toggling 1,0,1,1,1 → exactly 4 wr_data_read[3] pulses; no request offered until the 4th read; ARB re-entered next cycle.
- Port 2 AMO write, burst field=5 → exactly 1 data word consumed.
- mem_rd_id={1,2'b10}, valid → rd_data_valid=4'b0010, rd_sub_id=2'b10; rst asserted mid-burst → all outputs 0 next cycle, state ARB.
